bus_arb: RTL
============

Name: bus_arb

Overview:
- Two-master, one-slave arbiter placed between the CPU's bus ports and the `mem` slave.
- m0 = instruction fetch, m1 = load/store.
- Each master port buffers one request. Contention is resolved round-robin. Exactly one transaction is outstanding at the slave at any time.
- All ports use the exec/fin/busy/sel/we handshake that `mem` already speaks.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 64, cycles allowed between slave exec and slave fin; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_m0_exec / i_m1_exec  in  1  request strobe; accepted when exec=1 and that master's busy=0.
- i_m0_addr / i_m1_addr  in  AW  request address.
- i_m0_data / i_m1_data  in  DW  write data.
- i_m0_sel / i_m1_sel  in  3  access size/sign code (funct3 encoding), passed through unchanged.
- i_m0_we / i_m1_we  in  1  write enable.
- o_m0_data / o_m1_data  out  DW  read data; valid while fin=1, held until that master's next fin.
- o_m0_fin / o_m1_fin  out  1  one-cycle completion pulse.
- o_m0_busy / o_m1_busy  out  1  that master's request slot is occupied.
- o_s_exec  out  1  one-cycle request pulse to the slave.
- o_s_addr / o_s_data / o_s_sel / o_s_we  out  AW/DW/3/1  registered request fields to the slave.
- i_s_data  in  DW  slave read data.
- i_s_fin  in  1  slave completion pulse.
- i_s_busy  in  1  slave cannot accept a request.

Behaviour:
- Reset values: all o_* outputs 0; both slots empty; state IDLE; round-robin pointer last=1, so m0 wins the first contention.

Request slots:
- On acceptance, addr/data/sel/we are latched into that master's slot and pend is set.
- o_mN_busy = pend_N, registered.
- exec while busy=1 is ignored, with no side effect.

State machine:
- IDLE:
  - Taken if any pend is set and i_s_busy=0.
  - Grant g: if only one master is pending, g is that master; if both are pending, g = ~last.
  - Drive o_s_exec=1 for one cycle, load o_s_* from slot g, set last=g, go to WAIT.
  - If i_s_busy=1, stay in IDLE with no exec.
- WAIT:
  - o_s_* held stable; o_s_exec=0.
  - On i_s_fin=1: capture i_s_data into o_mg_data, clear pend_g, pulse o_mg_fin on the next cycle, go to IDLE.
- A request may be accepted in the same cycle it becomes visible as fin=1/busy=0. Fin and new acceptance in the same cycle are legal.

Latency:
- Request accepted at cycle t, with slave fin L cycles after its exec.
- o_s_exec at t+1.
- o_mN_fin at t+2+L.
- Minimum IDLE revisit between back-to-back grants: 1 cycle.

Boundary cases:
- Both masters exec in the same cycle from empty: both latched, served in round-robin order.
- A master cannot be starved: after being passed over once, it wins the next grant.
- i_s_fin in IDLE (stray fin, or a fin after reset): ignored.
- Reset mid-WAIT: slots cleared, state IDLE, no fin emitted. Any fin for the old transaction is then ignored.
- o_m0_fin and o_m1_fin are never 1 in the same cycle.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter is cleared on o_s_exec and increments in WAIT.
  - On reaching TIMEOUT without i_s_fin: o_mg_data=32'hDEADBEEF, o_mg_fin pulses, ports o_m0_err / o_m1_err (1 bit) pulse together with that fin, pend_g is cleared, state returns to IDLE.
  - A later stray i_s_fin is ignored.
- Without the macro: no counter and no err ports; WAIT waits indefinitely.

Decomposition:
- Shared package bus_pkg holds:
  - state encoding constants ST_IDLE and ST_WAIT;
  - sel codes SEL_B, SEL_H, SEL_W, SEL_BU, SEL_HU;
  - the DEADBEEF error word.
- Sub-module bus_arb_slot: a one-entry request buffer (accept / latch / clear / busy), instantiated once per master.

Test Plan:
- m0 read, addr 0x10, slave fin 2 cycles after exec:
  - o_s_exec at t+1 with o_s_addr=0x10;
  - o_m0_fin at t+4 with o_m0_data equal to the slave word;
  - o_m0_busy is 1 from t+1 through t+3.
- m0 and m1 exec at the same cycle from reset:
  - m0 is served first and m1 second;
  - next contention goes to m0 again (last=1 after m1).
- m1 write, we=1, data 0xCAFEF00D, sel=SEL_W, with i_s_busy=1 for 3 cycles:
  - o_s_exec is held off until i_s_busy falls;
  - o_s_data=0xCAFEF00D and o_s_we=1 at exec;
  - o_m1_fin pulses once.
- m0 issues exec again in the cycle o_m0_fin=1, for 4 consecutive requests:
  - all accepted;
  - each o_s_exec spaced 1 IDLE cycle after the previous slave fin.
- Reset asserted during WAIT, then a stray i_s_fin:
  - all outputs 0;
  - no master fin;
  - the following m1 request completes normally.
- With BUS_ARB_TIMEOUT_EN, TIMEOUT=8, slave never fins:
  - o_m0_fin and o_m0_err pulse 9 cycles after o_s_exec with data 0xDEADBEEF;
  - the arbiter is back in IDLE.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state encoding,
// funct3-style access size codes and the word returned on a slave timeout.
package bus_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [2:0] SEL_B  = 3'b000;
   localparam logic [2:0] SEL_H  = 3'b001;
   localparam logic [2:0] SEL_W  = 3'b010;
   localparam logic [2:0] SEL_BU = 3'b100;
   localparam logic [2:0] SEL_HU = 3'b101;

   localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/bus_arb_slot.sv
// One-entry request buffer for a single master port. The req_* outputs
// show the stored request once the slot is occupied, and the incoming
// request while it is empty, so the arbiter can issue a request in the
// very cycle it is accepted.
module bus_arb_slot #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          exec,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data,
   input  logic [2:0]    sel,
   input  logic          we,
   input  logic          clear,
   output logic          busy,
   output logic          valid,
   output logic [AW-1:0] req_addr,
   output logic [DW-1:0] req_data,
   output logic [2:0]    req_sel,
   output logic          req_we
);

   logic          pend;
   logic          accept;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic [2:0]    sel_q;
   logic          we_q;

   // A strobe while the slot is full is dropped without touching anything
   assign accept = exec && !pend;

   // Occupancy flag: set on acceptance, dropped when the arbiter retires the request
   always_ff @(posedge clk) begin
      if (rst)
         pend <= 1'b0;
      else if (clear)
         pend <= 1'b0;
      else if (accept)
         pend <= 1'b1;
   end

   // Request fields are captured only when the slot takes a new request
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q <= addr;
         data_q <= data;
         sel_q  <= sel;
         we_q   <= we;
      end
   end

   assign busy     = pend;
   assign valid    = pend || exec;
   assign req_addr = pend ? addr_q : addr;
   assign req_data = pend ? data_q : data;
   assign req_sel  = pend ? sel_q  : sel;
   assign req_we   = pend ? we_q   : we;

endmodule

// File: rtl/bus_arb.sv
// Two-master, one-slave round-robin bus arbiter (m0 = fetch, m1 = load/store).
// One transaction is outstanding at the slave at a time. Optional slave
// timeout with per-master error pulse: define BUS_ARB_TIMEOUT_EN.
module bus_arb
   import bus_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_m0_exec,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [DW-1:0] i_m0_data,
   input  logic [2:0]    i_m0_sel,
   input  logic          i_m0_we,
   input  logic          i_m1_exec,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [DW-1:0] i_m1_data,
   input  logic [2:0]    i_m1_sel,
   input  logic          i_m1_we,
   output logic [DW-1:0] o_m0_data,
   output logic [DW-1:0] o_m1_data,
   output logic          o_m0_fin,
   output logic          o_m1_fin,
   output logic          o_m0_busy,
   output logic          o_m1_busy,
`ifdef BUS_ARB_TIMEOUT_EN
   output logic          o_m0_err,
   output logic          o_m1_err,
`endif
   output logic          o_s_exec,
   output logic [AW-1:0] o_s_addr,
   output logic [DW-1:0] o_s_data,
   output logic [2:0]    o_s_sel,
   output logic          o_s_we,
   input  logic [DW-1:0] i_s_data,
   input  logic          i_s_fin,
   input  logic          i_s_busy
);

   logic          valid0, valid1;
   logic [AW-1:0] r0_addr, r1_addr;
   logic [DW-1:0] r0_data, r1_data;
   logic [2:0]    r0_sel, r1_sel;
   logic          r0_we, r1_we;
   state_t        state;
   logic          last;
   logic          gnt;
   logic          pick;
   logic          done;
   logic          to_hit;
   logic [DW-1:0] fin_data;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("bus_arb: TIMEOUT must be at least 1");
   end

   bus_arb_slot #(.AW(AW), .DW(DW)) u_slot0 (
      .clk(i_clk), .rst(i_reset), .exec(i_m0_exec), .addr(i_m0_addr),
      .data(i_m0_data), .sel(i_m0_sel), .we(i_m0_we), .clear(done && !gnt),
      .busy(o_m0_busy), .valid(valid0), .req_addr(r0_addr),
      .req_data(r0_data), .req_sel(r0_sel), .req_we(r0_we)
   );

   bus_arb_slot #(.AW(AW), .DW(DW)) u_slot1 (
      .clk(i_clk), .rst(i_reset), .exec(i_m1_exec), .addr(i_m1_addr),
      .data(i_m1_data), .sel(i_m1_sel), .we(i_m1_we), .clear(done && gnt),
      .busy(o_m1_busy), .valid(valid1), .req_addr(r1_addr),
      .req_data(r1_data), .req_sel(r1_sel), .req_we(r1_we)
   );

   // Round-robin choice: a lone requester wins outright, contention goes to the master not served last
   always_comb begin
      pick = 1'b0;
      if (valid0 && valid1)
         pick = !last;
      else if (valid1)
         pick = 1'b1;
   end

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;

   // A real slave fin in the timeout cycle takes priority over the error
   assign to_hit = (state == ST_WAIT) && (cnt == CW'(TIMEOUT)) && !i_s_fin;

   // Cycles spent waiting on the slave; held at zero while idle so it starts clean at each exec
   always_ff @(posedge i_clk) begin
      if (i_reset || state == ST_IDLE)
         cnt <= '0;
      else if (!to_hit)
         cnt <= cnt + 1'b1;
   end
`else
   assign to_hit = 1'b0;
`endif

   // The outstanding transaction retires on slave fin (or timeout); fins seen in IDLE are ignored
   assign done     = (state == ST_WAIT) && (i_s_fin || to_hit);
   assign fin_data = to_hit ? DW'(ERR_WORD) : i_s_data;

   // Arbiter FSM: issue one granted request to the slave, then route its completion back
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         last      <= 1'b1;
         gnt       <= 1'b0;
         o_s_exec  <= 1'b0;
         o_s_addr  <= '0;
         o_s_data  <= '0;
         o_s_sel   <= '0;
         o_s_we    <= 1'b0;
         o_m0_fin  <= 1'b0;
         o_m1_fin  <= 1'b0;
         o_m0_data <= '0;
         o_m1_data <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
         o_m0_err  <= 1'b0;
         o_m1_err  <= 1'b0;
`endif
      end else begin
         o_s_exec <= 1'b0;
         o_m0_fin <= 1'b0;
         o_m1_fin <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
         o_m0_err <= 1'b0;
         o_m1_err <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if ((valid0 || valid1) && !i_s_busy) begin
                  o_s_exec <= 1'b1;
                  o_s_addr <= pick ? r1_addr : r0_addr;
                  o_s_data <= pick ? r1_data : r0_data;
                  o_s_sel  <= pick ? r1_sel  : r0_sel;
                  o_s_we   <= pick ? r1_we   : r0_we;
                  last     <= pick;
                  gnt      <= pick;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (done) begin
                  if (gnt) begin
                     o_m1_fin  <= 1'b1;
                     o_m1_data <= fin_data;
                  end else begin
                     o_m0_fin  <= 1'b1;
                     o_m0_data <= fin_data;
                  end
`ifdef BUS_ARB_TIMEOUT_EN
                  o_m0_err <= to_hit && !gnt;
                  o_m1_err <= to_hit && gnt;
`endif
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
